fb_painter: RTL and testbench
=============================

Name: fb_painter

Overview:
- Drop-in `painter` that serves pixels from an internal double-buffered framebuffer instead of computing them.
- Consumes `<frame, subframe, x, y>` from the painter ticker and returns 1-bit-per-colour RGB for the LED driver.
- Each instance stores only its half of the 64x64 panel, so `led_main` instantiates two: upper half and lower half.
- Converts per-channel intensity to on/off per subframe by threshold (PWM) comparison.

Parameters:
- FRAME_BITS, 10, width of `frame` input.
- CHAN_BITS, 4, intensity bits per colour channel (1..8).
- Y_HALF, 0, which panel half this instance stores and serves (matches y[5]).

Ports:
- clk  in  1  pixel clock (pll_clk)
- reset  in  1  synchronous, active-high
- frame  in  FRAME_BITS  current frame number
- subframe  in  8  current subframe
- x  in  6  column
- y  in  6  row; y[5] is always Y_HALF during reads
- rgb  out  3  {b,g,r} on/off for pixel (x,y), 2 cycles after inputs
- wr_en  in  1  write strobe
- wr_x  in  6  write column
- wr_y  in  6  write row
- wr_rgb  in  3*CHAN_BITS  {b,g,r} intensities
- swap_req  in  1  single-cycle pulse: present back bank at next frame boundary
- swap_ack  out  1  single-cycle pulse when the swap takes effect

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Reset values: rgb=0, swap_ack=0, front bank=0, swap pending=0, frame_prev<=frame (no false boundary). RAM contents are not reset.
- Storage: 2 banks x 32 rows x 64 cols x 3*CHAN_BITS.
  - Read address is {front, y[4:0], x}.
  - Write address is {~front, wr_y[4:0], wr_x}.
- Writes:
  - Only when wr_en=1 and wr_y[5]==Y_HALF; other writes are silently ignored.
  - Writes always target the back bank.
  - A write lands in 1 cycle.
  - A write never alters the displayed image.
- Read pipeline, fixed latency 2, no stalls:
  - Cycle 0: x, y, subframe presented; RAM address registered; subframe delayed one stage.
  - Cycle 1: RAM data available.
  - Cycle 2: rgb registered.
  - Inputs change every cycle or pause; output is purely a function of inputs 2 cycles earlier plus the bank state at cycle 0.
- Modulation: thr = subframe[7 -: CHAN_BITS]. Colour bit = (chan > thr), unsigned, width CHAN_BITS.
  - chan=0 is always off.
  - chan=max is on for (2^CHAN_BITS - 1)/2^CHAN_BITS of subframes.
- Frame boundary: cycle where frame != frame_prev; frame_prev updates every cycle. Frame wrap (max->0) is a boundary.
- Swap FSM, states IDLE and PENDING:
  - IDLE: swap_req -> PENDING.
  - PENDING: on a boundary, front toggles, swap_ack=1 for one cycle, -> IDLE.
  - swap_req in the same cycle as a boundary, from IDLE: swap happens at that boundary.
  - swap_req while PENDING: ignored (no second swap).
  - swap_req in the same cycle as the ack: starts a new PENDING.
- Bank toggle timing: the toggle affects read addresses from the cycle after the boundary. Pixels already in the pipeline complete from the old bank.
- Write and swap in the same cycle: the write goes to the pre-swap back bank.
- Reset mid-frame: bank selection returns to 0; pending swap is dropped; pipeline outputs 0 for 2 cycles.

Decomposition:
- Package fb_pkg holds:
  - SB=8, CB=6, AB=5 constants;
  - LATENCY=2;
  - pixel word width function 3*CHAN_BITS;
  - swap-state encodings.
- Sub-module fb_ram: simple dual-port RAM, 1 write port, 1 read port with registered read, inferable to EBR. fb_painter holds the swap FSM, address muxing and threshold compare.

Test Plan:
- CHAN_BITS=4, Y_HALF=0: write (3,2)={r=8,g=0,b=15} to back, swap, wait boundary. Read (3,2) sweeping subframe 0..255 -> r on for subframe<128 (128 cycles), g never, b on for 240 of 256; rgb lags inputs exactly 2 cycles.
- Write with wr_y=40 on the Y_HALF=0 instance, then swap and read (x,8) -> unchanged (write ignored); same write on the Y_HALF=1 instance is visible after swap.
- Before any swap, write bank 1 pixel (0,0)=all 15 -> read (0,0) at subframe 0 still yields rgb=0 (front is bank 0).
- swap_req mid-frame at frame=5 -> no change until frame becomes 6; swap_ack pulses on exactly that cycle; a second swap_req while pending -> only one toggle.
- swap_req coincident with a boundary (frame 1023->0 wrap) -> swap at that boundary, ack same cycle.
- Assert reset while PENDING with front=1 -> after release front=0, swap_ack stays 0, rgb=0 for the first 2 cycles.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer-backed painter.
package fb_pkg;
  localparam int SB      = 8;  // subframe width
  localparam int CB      = 6;  // column / full-row coordinate width
  localparam int AB      = 5;  // row address width within one panel half
  localparam int LATENCY = 2;

  typedef enum logic {ST_IDLE = 1'b0, ST_PENDING = 1'b1} swap_st_e;

  function automatic int pix_w(input int chan_bits);
    return 3 * chan_bits;
  endfunction
endpackage

// File: rtl/fb_ram.sv
// Simple dual-port RAM: one write port, one registered read port (maps to EBR).
module fb_ram #(
  parameter int AW = 12,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/fb_painter.sv
// Painter that serves PWM-modulated pixels from a double-buffered half-panel framebuffer.
// Writes go to the back bank; a requested swap takes effect at the next frame boundary.
module fb_painter import fb_pkg::*; #(
  parameter int FRAME_BITS = 10,
  parameter int CHAN_BITS  = 4,
  parameter int Y_HALF     = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [FRAME_BITS-1:0]         frame,
  input  logic [SB-1:0]                 subframe,
  input  logic [CB-1:0]                 x,
  input  logic [CB-1:0]                 y,
  output logic [2:0]                    rgb,
  input  logic                          wr_en,
  input  logic [CB-1:0]                 wr_x,
  input  logic [CB-1:0]                 wr_y,
  input  logic [pix_w(CHAN_BITS)-1:0]   wr_rgb,
  input  logic                          swap_req,
  output logic                          swap_ack
);
  localparam int PW = pix_w(CHAN_BITS);
  localparam int AW = 1 + AB + CB;

  swap_st_e              r_state, w_state_nx;
  logic                  r_front, w_swap, w_boundary, w_we, r_vld;
  logic [FRAME_BITS-1:0] r_frame_prev;
  logic [CHAN_BITS-1:0]  r_thr;
  logic [PW-1:0]         w_rdata;
  logic [2:0]            r_rgb, w_on;
  logic                  w_unused;

  assign w_boundary = (frame != r_frame_prev);
  assign w_we       = wr_en && (wr_y[CB-1] == 1'(Y_HALF));
  // Low subframe bits and y[5] are not needed by the datapath.
  assign w_unused   = ^{subframe, y[CB-1]};

  fb_ram #(.AW(AW), .DW(PW)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr ({~r_front, wr_y[AB-1:0], wr_x}),
    .i_wdata (wr_rgb),
    .i_raddr ({r_front, y[AB-1:0], x}),
    .o_rdata (w_rdata)
  );

  for (genvar c = 0; c < 3; c++) begin : g_chan
    assign w_on[c] = w_rdata[c*CHAN_BITS +: CHAN_BITS] > r_thr;
  end

  always_comb begin
    w_state_nx = r_state;
    w_swap     = 1'b0;
    case (r_state)
      ST_IDLE: if (swap_req) begin
        if (w_boundary) w_swap = 1'b1;
        else            w_state_nx = ST_PENDING;
      end
      ST_PENDING: if (w_boundary) begin
        w_swap     = 1'b1;
        w_state_nx = swap_req ? ST_PENDING : ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
    if (reset) w_swap = 1'b0;
  end

  // r_vld masks the stale RAM word read while reset was held.
  always_ff @(posedge clk) begin
    r_frame_prev <= frame;
    r_thr        <= subframe[SB-1 -: CHAN_BITS];
    if (reset) begin
      r_state <= ST_IDLE;
      r_front <= 1'b0;
      r_vld   <= 1'b0;
      r_rgb   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_front <= r_front ^ w_swap;
      r_vld   <= 1'b1;
      r_rgb   <= r_vld ? w_on : 3'b000;
    end
  end

  assign rgb      = r_rgb;
  assign swap_ack = w_swap;
endmodule

// File: tb/tb_fb_painter.sv
// Bench for fb_painter: lower- and upper-half instances against an array-based panel model.
module tb_fb_painter;
  localparam int FB = 10;
  localparam int CB = 4;
  localparam int PW = 3 * CB;

  logic          clk = 1'b0;
  logic          reset;
  logic [FB-1:0] frame;
  logic [7:0]    subframe;
  logic [5:0]    x, y, y1;
  logic          wr_en;
  logic [5:0]    wr_x, wr_y;
  logic [PW-1:0] wr_rgb;
  logic          swap_req;
  logic [2:0]    rgb0, rgb1;
  logic          ack0, ack1;

  int checks = 0;
  int failures = 0;

  logic [PW-1:0] m_mem   [2][2][32][64];  // [half][bank][row][col]
  bit            m_known [2][2][32][64];
  int            m_front;
  bit            m_pend;
  logic [FB-1:0] m_fprev;
  int            q0[$], q1[$];
  logic          last_ack;

  always #5 clk = ~clk;
  assign y1 = {1'b1, y[4:0]};

  fb_painter #(.FRAME_BITS(FB), .CHAN_BITS(CB), .Y_HALF(0)) u_dut0 (
    .clk(clk), .reset(reset), .frame(frame), .subframe(subframe), .x(x), .y(y),
    .rgb(rgb0), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
    .swap_req(swap_req), .swap_ack(ack0));

  fb_painter #(.FRAME_BITS(FB), .CHAN_BITS(CB), .Y_HALF(1)) u_dut1 (
    .clk(clk), .reset(reset), .frame(frame), .subframe(subframe), .x(x), .y(y1),
    .rgb(rgb1), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
    .swap_req(swap_req), .swap_ack(ack1));

  // A channel is lit while its intensity exceeds the subframe's position within 2^CB steps.
  function automatic int exp_pix(input logic [PW-1:0] w, input logic [7:0] sf);
    int thr, res, ch;
    thr = int'(sf) / (256 / (1 << CB));
    res = 0;
    for (int c = 0; c < 3; c++) begin
      ch = (int'(w) >> (c * CB)) % (1 << CB);
      if (ch > thr) res = res + (1 << c);
    end
    return res;
  endfunction

  // One clock: predict this cycle, advance the model, then score rgb from two cycles back.
  task automatic tick();
    logic bnd, ack_e;
    int   e0, e1;
    #1;
    bnd   = (frame != m_fprev);
    ack_e = !reset && bnd && (m_pend || swap_req);
    last_ack = ack0;
    checks++;
    if (ack0 !== ack_e || ack1 !== ack_e) begin
      failures++;
      $display("FAIL swap_ack t=%0t got %b/%b want %b", $time, ack0, ack1, ack_e);
    end
    if (reset) begin
      foreach (q0[i]) q0[i] = 0;
      foreach (q1[i]) q1[i] = 0;
      e0 = 0;
      e1 = 0;
    end else begin
      e0 = m_known[0][m_front][y[4:0]][x] ? exp_pix(m_mem[0][m_front][y[4:0]][x], subframe) : -1;
      e1 = m_known[1][m_front][y[4:0]][x] ? exp_pix(m_mem[1][m_front][y[4:0]][x], subframe) : -1;
    end
    q0.push_back(e0);
    q1.push_back(e1);
    if (reset) begin
      m_front = 0;
      m_pend  = 0;
    end else begin
      if (wr_en) begin
        m_mem[wr_y[5]][m_front ^ 1][wr_y[4:0]][wr_x]   = wr_rgb;
        m_known[wr_y[5]][m_front ^ 1][wr_y[4:0]][wr_x] = 1'b1;
      end
      if (ack_e) m_pend = m_pend && swap_req;
      else if (swap_req) m_pend = 1'b1;
      if (ack_e) m_front = m_front ^ 1;
    end
    m_fprev = frame;
    @(posedge clk);
    @(negedge clk);
    if (q0.size() == 2) begin
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      if (e0 >= 0) begin
        checks++;
        if (rgb0 !== 3'(e0)) begin
          failures++;
          $display("FAIL rgb_lo t=%0t got %b want %b", $time, rgb0, 3'(e0));
        end
      end
      if (e1 >= 0) begin
        checks++;
        if (rgb1 !== 3'(e1)) begin
          failures++;
          $display("FAIL rgb_hi t=%0t got %b want %b", $time, rgb1, 3'(e1));
        end
      end
    end
  endtask

  task automatic do_swap();
    wr_en = 1'b0;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    frame++;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (rgb0 !== 3'b000 || rgb1 !== 3'b000) begin
      failures++;
      $display("FAIL reset_rgb got %b/%b want 000", rgb0, rgb1);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4096; i++) begin
        wr_en = 1'b1; wr_x = 6'(i % 64); wr_y = 6'(i / 64); wr_rgb = '0;
        x = 6'($urandom); y = {1'b0, 5'($urandom)}; subframe = 8'($urandom);
        tick();
      end
      do_swap();
    end
  endtask

  task automatic test_back_write();
    wr_en = 1'b1; wr_x = 6'd0; wr_y = 6'd0; wr_rgb = '1;
    tick();
    wr_en = 1'b0; x = 6'd0; y = 6'd0; subframe = 8'd0;
    tick();
    tick();
    checks++;
    if (rgb0 !== 3'b000) begin
      failures++;
      $display("FAIL back_write_hidden got %b want 000", rgb0);
    end
  endtask

  task automatic test_pwm();
    int rc, gc, bc;
    wr_en = 1'b1; wr_x = 6'd3; wr_y = 6'd2; wr_rgb = {4'd15, 4'd0, 4'd8};
    tick();
    do_swap();
    rc = 0; gc = 0; bc = 0;
    x = 6'd3; y = 6'd2;
    for (int k = 0; k <= 256; k++) begin
      subframe = 8'(k);
      tick();
      if (k >= 1) begin
        rc += int'(rgb0[0]); gc += int'(rgb0[1]); bc += int'(rgb0[2]);
      end
    end
    checks++;
    if (rc != 128 || gc != 0 || bc != 240) begin
      failures++;
      $display("FAIL pwm_counts got r=%0d g=%0d b=%0d want r=128 g=0 b=240", rc, gc, bc);
    end
  endtask

  task automatic test_half_select();
    wr_en = 1'b1; wr_x = 6'd5; wr_y = 6'd40; wr_rgb = '1;
    tick();
    do_swap();
    x = 6'd5; y = 6'd8; subframe = 8'd0;
    tick();
    tick();
    checks++;
    if (rgb0 !== 3'b000 || rgb1 !== 3'b111) begin
      failures++;
      $display("FAIL half_select got lo=%b hi=%b want lo=000 hi=111", rgb0, rgb1);
    end
  endtask

  task automatic test_swap_timing();
    int acks;
    frame = 10'd5;
    tick(); tick();
    acks = 0;
    swap_req = 1'b1; tick(); acks += int'(last_ack);
    swap_req = 1'b0;
    repeat (3) begin tick(); acks += int'(last_ack); end
    swap_req = 1'b1; tick(); acks += int'(last_ack);
    swap_req = 1'b0; tick(); acks += int'(last_ack);
    checks++;
    if (acks != 0) begin
      failures++;
      $display("FAIL swap_early got acks=%0d want 0", acks);
    end
    frame = 10'd6;
    tick();
    checks++;
    if (last_ack !== 1'b1) begin
      failures++;
      $display("FAIL swap_at_boundary got %b want 1", last_ack);
    end
    acks = 0;
    repeat (3) begin tick(); acks += int'(last_ack); end
    frame = 10'd7;
    tick(); acks += int'(last_ack);
    checks++;
    if (acks != 0) begin
      failures++;
      $display("FAIL swap_single got extra acks=%0d want 0", acks);
    end
  endtask

  task automatic test_wrap_swap();
    frame = 10'd1023;
    tick(); tick();
    frame = 10'd0; swap_req = 1'b1;
    tick();
    checks++;
    if (last_ack !== 1'b1) begin
      failures++;
      $display("FAIL wrap_swap got %b want 1", last_ack);
    end
    swap_req = 1'b0; tick();
    frame = 10'd1; tick();
    checks++;
    if (last_ack !== 1'b0) begin
      failures++;
      $display("FAIL wrap_no_repeat got %b want 0", last_ack);
    end
  endtask

  task automatic test_rearm();
    swap_req = 1'b1; tick();
    swap_req = 1'b0; tick();
    frame++; swap_req = 1'b1; tick();
    checks++;
    if (last_ack !== 1'b1) begin
      failures++;
      $display("FAIL rearm_first got %b want 1", last_ack);
    end
    swap_req = 1'b0; tick(); tick();
    frame++; tick();
    checks++;
    if (last_ack !== 1'b1) begin
      failures++;
      $display("FAIL rearm_second got %b want 1", last_ack);
    end
  endtask

  task automatic test_reset_mid();
    if (m_front == 0) do_swap();
    x = 6'd0; y = 6'd0; subframe = 8'd0;
    swap_req = 1'b1; tick();
    swap_req = 1'b0; tick(); tick();
    reset = 1'b1; tick(); tick();
    reset = 1'b0;
    checks++;
    if (rgb0 !== 3'b000) begin
      failures++;
      $display("FAIL reset_flush0 got %b want 000", rgb0);
    end
    tick();
    checks++;
    if (rgb0 !== 3'b000) begin
      failures++;
      $display("FAIL reset_flush1 got %b want 000", rgb0);
    end
    frame++; tick();
    checks++;
    if (last_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_drops_pending got %b want 0", last_ack);
    end
    tick(); tick();
    checks++;
    if (rgb0 !== 3'b000) begin
      failures++;
      $display("FAIL reset_front0 got %b want 000", rgb0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom % 400) == 0;
      wr_en    = !reset && (($urandom % 3) == 0);
      wr_x     = 6'($urandom); wr_y = 6'($urandom); wr_rgb = PW'($urandom);
      x        = 6'($urandom); y = {1'b0, 5'($urandom)}; subframe = 8'($urandom);
      swap_req = ($urandom % 25) == 0;
      if (($urandom % 15) == 0) frame++;
      tick();
    end
    reset = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
    tick(); tick();
  endtask

  initial begin
    reset = 1'b1; frame = '0; subframe = '0; x = '0; y = '0;
    wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_rgb = '0; swap_req = 1'b0;
    m_front = 0; m_pend = 1'b0; m_fprev = frame; last_ack = 1'b0;
    test_reset();
    test_fill();
    test_back_write();
    test_pwm();
    test_half_select();
    test_swap_timing();
    test_wrap_swap();
    test_rearm();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
